// File: rtl/program_loader.sv
// Byte-stream loader for the CPU program memory: 16-bit length header, then one command word
// per BYTES_PER_WORD bytes. Optional trailing XOR checksum via PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned COMMAND_SIZE   = 33,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned BYTES_PER_WORD = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  output logic                    in_ready_o,
  output logic                    prog_we_o,
  output logic [ADDR_WIDTH-1:0]   prog_addr_o,
  output logic [COMMAND_SIZE-1:0] prog_wdata_o,
  output logic [ADDR_WIDTH:0]     words_loaded_o,
  output logic                    cpu_hold_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned CntW   = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned LenMax = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StPayload, StWrite, StDone, StErr
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [COMMAND_SIZE-1:0] asm_q, asm_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]     words_q, words_d;
  logic [15:0]             len_new;
  logic                    xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]              chk_q, chk_d;
  localparam state_e       StLast = StChk;
`else
  localparam state_e       StLast = StDone;
`endif

  assign xfer    = in_valid_i && in_ready_o;
  assign len_new = {len_q[15:8], in_data_i};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    in_ready_o = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StLenHi;
          words_d = '0;
          cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      StLenHi: begin
        in_ready_o = 1'b1;
        if (xfer) begin
          len_d[15:8] = in_data_i;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        in_ready_o = 1'b1;
        if (xfer) begin
          len_d[7:0] = in_data_i;
          if (len_new == 16'd0)             state_d = StLast;
          else if (32'(len_new) > LenMax)   state_d = StErr;
          else                              state_d = StPayload;
        end
      end
      StPayload: begin
        in_ready_o = 1'b1;
        if (xfer) begin
          // Shifting into a COMMAND_SIZE-wide register drops the unused top bits of byte 0.
          asm_d = {asm_q[COMMAND_SIZE-9:0], in_data_i};
          cnt_d = cnt_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data_i;
`endif
          if (cnt_q == CntW'(BYTES_PER_WORD - 1)) state_d = StWrite;
        end
      end
      StWrite: begin
        words_d = words_q + 1'b1;
        cnt_d   = '0;
        if (32'(words_q) + 32'd1 == 32'(len_q)) state_d = StLast;
        else                                    state_d = StPayload;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StChk: begin
        in_ready_o = 1'b1;
        if (xfer) state_d = (in_data_i == chk_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
      words_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign prog_we_o      = (state_q == StWrite);
  assign prog_addr_o    = words_q[ADDR_WIDTH-1:0];
  assign prog_wdata_o   = asm_q;
  assign words_loaded_o = words_q;
  assign cpu_hold_o     = (state_q != StDone);
  assign done_o         = (state_q == StDone);
  assign err_o          = (state_q == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: expected writes and load outcome come from the image
// contents and length rules, checked every cycle by a monitor process.
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, prog_we, cpu_hold, done, err;
  logic [9:0]  prog_addr;
  logic [32:0] prog_wdata;
  logic [10:0] words_loaded;

  program_loader dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .prog_we_o(prog_we), .prog_addr_o(prog_addr),
    .prog_wdata_o(prog_wdata), .words_loaded_o(words_loaded), .cpu_hold_o(cpu_hold),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [32:0] mem [0:1023];
  int unsigned exp_addr[$];
  logic [32:0] exp_data[$];
  logic [7:0]  payload[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the next expected (addr, word); status invariants hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (prog_we) begin
        mem[prog_addr] = prog_wdata;
        if (exp_addr.size() == 0) chk("unexpected write", 1, 0);
        else begin
          chk("write addr", prog_addr, exp_addr.pop_front());
          chk("write data", prog_wdata, exp_data.pop_front());
        end
        chk("in_ready during write", in_ready, 0);
      end
      chk("status invariants", {cpu_hold, done && err, (done || err) && in_ready},
          {!done, 1'b0, 1'b0});
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
    end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("handshake timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " prog_we"}, prog_we, 0);
    chk({tag, " prog_addr"}, prog_addr, 0);
    chk({tag, " prog_wdata"}, prog_wdata, 0);
    chk({tag, " words_loaded"}, words_loaded, 0);
    chk({tag, " cpu_hold"}, cpu_hold, 1);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each byte.
  task automatic run_load(input logic [15:0] len, input bit exp_err, input int gap,
                          input bit mid_start, input bit bad_chk);
    int          nw = exp_err ? 0 : int'(len);
    logic [7:0]  xr = 8'h00;
    logic [39:0] w;
    int          lat = 0, exp_lat, g;
    bit          fail_exp = exp_err || (ChkEn && bad_chk);
    for (int i = 0; i < nw; i++) begin
      w = {payload[5*i], payload[5*i+1], payload[5*i+2], payload[5*i+3], payload[5*i+4]};
      exp_addr.push_back(i);
      exp_data.push_back(w[32:0]);
    end
    pulse_start();
    send_byte(len[15:8], 0);
    send_byte(len[7:0], 0);
    for (int i = 0; i < payload.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      send_byte(payload[i], g);
      xr ^= payload[i];
      if (mid_start && i == 2) pulse_start();
    end
    if (ChkEn && !exp_err) send_byte(bad_chk ? (xr ^ 8'h01) : xr, 0);
    exp_lat = (!ChkEn && nw > 0) ? 1 : 0;
    @(negedge clk);
    while (!(done || err) && lat < 20) begin @(negedge clk); lat++; end
    chk("completion latency", lat, exp_lat);
    chk("done", done, !fail_exp);
    chk("err", err, fail_exp);
    chk("cpu_hold", cpu_hold, fail_exp);
    chk("words_loaded", words_loaded, nw);
    chk("writes outstanding", exp_addr.size(), 0);
  endtask

  task automatic rand_payload(input int nw);
    payload = {};
    for (int i = 0; i < 5 * nw; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle in_ready", in_ready, 0);

    // Two-word image with known contents.
    payload = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    run_load(16'd2, 1'b0, 0, 1'b0, 1'b0);
    chk("mem[0] literal", mem[0], 33'h123456789);
    chk("mem[1] literal", mem[1], 33'h000000001);
    chk("words_loaded literal", words_loaded, 2);

    // Empty image.
    payload = {};
    run_load(16'd0, 1'b0, 0, 1'b0, 1'b0);

    // Oversized lengths abort, then a valid image recovers.
    run_load(16'd1025, 1'b1, 0, 1'b0, 1'b0);
    run_load(16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
    rand_payload(3);
    run_load(16'd3, 1'b0, -1, 1'b0, 1'b0);

    // Top bits of byte 0 are discarded.
    payload = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(16'd1, 1'b0, 0, 1'b0, 1'b0);
    chk("mem[0] all-ones literal", mem[0], 33'h1FFFFFFFF);

    // Throttled valid with an ignored start mid-payload.
    rand_payload(1);
    run_load(16'd1, 1'b0, 1, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int n = int'($urandom_range(6, 1));
      rand_payload(n);
      run_load(16'(n), 1'b0, -1, 1'b0, 1'b0);
    end

    // Full memory: last address 1023.
    rand_payload(1024);
    run_load(16'd1024, 1'b0, 0, 1'b0, 1'b0);
    chk("mem[1023] after full load", mem[1023],
        {payload[5115][0], payload[5116], payload[5117], payload[5118], payload[5119]});

    // Reset in the middle of a payload.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid-load reset");
    exp_addr = {};
    exp_data = {};
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_ready after reset", in_ready, 0);
    end
    rand_payload(2);
    run_load(16'd2, 1'b0, -1, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    payload = {8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
    run_load(16'd1, 1'b0, 0, 1'b0, 1'b0);
    run_load(16'd1, 1'b0, 0, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the pipelined CPU's program memory.
- Accepts a byte stream over a valid/ready handshake and assembles 33-bit command words (4-bit opcode, address, literal).
- Writes each word to program memory at sequential addresses.
- Holds the CPU in reset until the whole image is loaded, so the CPU fetches from address 0 only after a complete load.

Parameters:
- COMMAND_SIZE, 33, width of one command word.
- ADDR_WIDTH, 10, program-memory address width (1024 words).
- BYTES_PER_WORD, 5, stream bytes per command; must satisfy 8*BYTES_PER_WORD >= COMMAND_SIZE.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a new load.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- prog_we  output  1  program-memory write strobe.
- prog_addr  output  ADDR_WIDTH  program-memory write address.
- prog_wdata  output  COMMAND_SIZE  assembled command word.
- words_loaded  output  ADDR_WIDTH+1  number of words written in the current/last load.
- cpu_hold  output  1  drive to the CPU reset; high while loading.
- done  output  1  load completed without error; sticky until the next start.
- err  output  1  load aborted; sticky until the next start.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE.
  - in_ready=0, prog_we=0, prog_addr=0, prog_wdata=0, words_loaded=0.
  - cpu_hold=1, done=0, err=0.
  - The CPU stays held from power-up until the first successful load.
- A byte is transferred on a clk edge where in_valid && in_ready. in_data is ignored otherwise.
- States:
  - IDLE: in_ready=0. start -> LEN_HI. On entry from start: cpu_hold=1, done=0, err=0, words_loaded=0, prog_addr=0, byte counter=0.
  - LEN_HI: in_ready=1. Transfer -> len[15:8], go to LEN_LO.
  - LEN_LO: in_ready=1. Transfer -> len[7:0].
    - len==0: go to DONE.
    - len>2^ADDR_WIDTH: go to ERR.
    - otherwise: go to PAYLOAD.
  - PAYLOAD: in_ready=1. Each transfer shifts the byte into a 40-bit assembly register (big-endian; first byte most significant). On the BYTES_PER_WORD-th byte, go to WRITE.
  - WRITE: exactly one cycle.
    - Outputs: in_ready=0, prog_we=1, prog_wdata = low COMMAND_SIZE bits of the assembly register.
    - Upper unused bits (byte0[7:1]) are discarded.
    - Next edge: prog_addr+=1, words_loaded+=1, byte counter=0.
    - If words_loaded+1==len, go to DONE (or CHK when CHECKSUM_EN is defined); else go to PAYLOAD.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> IDLE-entry actions, then LEN_HI.
  - ERR: err=1, cpu_hold=1, in_ready=0. Only start exits (to LEN_HI).
- start in LEN_HI, LEN_LO, PAYLOAD or WRITE is ignored. Loads cannot be interrupted except by reset.
- Throughput: at most one word per BYTES_PER_WORD+1 cycles. in_valid may drop between bytes with no loss.
- The last address written is len-1. prog_addr never wraps: the len check forbids it.
- Reset mid-load returns to reset values. Words already written stay in memory. cpu_hold reasserts immediately (asynchronously).

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, state CHK (in_ready=1) accepts one byte.
  - That byte must equal the XOR of all payload bytes (length bytes excluded).
  - Match -> DONE. Mismatch -> ERR.
  - len==0 also goes through CHK with an expected value of 0x00.
- Undefined: CHK does not exist. The transfer after the last word's bytes belongs to the next load and is not accepted (in_ready=0).

Test Plan:
1. Reset, start, stream 00 02, 01 23 45 67 89, 00 00 00 00 01 -> prog_we pulses twice: addr0=0x123456789, addr1=0x000000001; done=1; cpu_hold falls the cycle after the second write; words_loaded=2.
2. Start, stream 00 00 -> DONE with no prog_we; done=1, words_loaded=0.
3. Start, stream 04 01 (len=1025) -> err=1, cpu_hold stays 1, no writes. A following start plus a valid image -> done=1, err=0.
4. Valid 1-word image with in_valid toggling every other cycle, plus a start pulse mid-payload -> start is ignored; the word is written correctly to address 0; done=1.
5. Assert reset after 3 payload bytes -> all outputs return to reset values immediately; after release, in_ready=0 until start.
6. (CHECKSUM_EN) Image 00 01, 00 00 00 00 0F, checksum 0F -> done=1. The same image with checksum 0E -> err=1, cpu_hold=1.
